// File: rtl/audio_pkg.sv
// Shared audio types for the mixer-to-I2S path: stereo frame layout and channel codes.
// Pure declarations; no timing or backpressure of its own.
package audio_pkg;
  localparam int SAMPLE_WIDTH = 16;

  localparam logic I2S_CHANNEL_LEFT  = 1'b0;
  localparam logic I2S_CHANNEL_RIGHT = 1'b1;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } StereoFrame;
endpackage

// File: rtl/i2s_clock_divider.sv
// Bit-clock generator: bclk toggles every CLK_DIV_HALF clk cycles, first rise CLK_DIV_HALF cycles after reset.
// Edge enables are combinational and high in the clk cycle whose closing edge toggles bclk; never stalls.
module i2s_clock_divider #(
  parameter int CLK_DIV_HALF = 8
) (
  input  logic aclk,
  input  logic aresetn,
  output logic bclk,
  output logic bclk_fall_en,
  output logic bclk_rise_en
);
  localparam int CW = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;

  logic [CW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          term;

  always_comb begin
    term         = (div_q == CW'(CLK_DIV_HALF - 1));
    div_d        = term ? '0 : div_q + CW'(1);
    bclk_d       = term ? ~bclk_q : bclk_q;
    bclk_fall_en = term && bclk_q;
    bclk_rise_en = term && !bclk_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
endmodule

// File: rtl/i2s_transmitter.sv
// I2S serializer with a one-frame holding register; lrclk/dout change on bclk falls, data one bit behind lrclk.
// sample_ready = holding empty; a frame load with nothing held plays zeros and pulses underrun.
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH,
  parameter int CLK_DIV_HALF = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    frame_tick,
  output logic                    underrun,
  output logic                    audio_bclk,
  output logic                    audio_lrclk,
  output logic                    audio_dout
);
  import audio_pkg::*;

  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int SW = $clog2(FW);

  logic          bclk_fall_en;
  logic          unused_rise_en;
  logic [SW-1:0] slot_q, slot_d;
  logic [FW-1:0] hold_q, hold_d;
  logic [FW-1:0] shift_q, shift_d;
  logic          ready_q, ready_d;
  logic          lrclk_q, lrclk_d;
  logic          dout_q, dout_d;
  logic          tick_q, tick_d;
  logic          underrun_q, underrun_d;
  logic          load;
  logic          xfer;

  i2s_clock_divider #(.CLK_DIV_HALF(CLK_DIV_HALF)) u_div (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .bclk         (audio_bclk),
    .bclk_fall_en (bclk_fall_en),
    .bclk_rise_en (unused_rise_en)
  );

  always_comb begin
    xfer       = sample_valid && ready_q;
    load       = bclk_fall_en && (slot_q == SW'(FW - 1));
    slot_d     = slot_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    ready_d    = ready_q;
    lrclk_d    = lrclk_q;
    dout_d     = dout_q;
    tick_d     = load;
    underrun_d = load && ready_q;

    if (bclk_fall_en) begin
      slot_d  = load ? '0 : slot_q + SW'(1);
      lrclk_d = (slot_d >= SW'(SAMPLE_WIDTH - 1) && slot_d <= SW'(FW - 2))
                ? I2S_CHANNEL_RIGHT : I2S_CHANNEL_LEFT;
      // MSB of the shifter is the bit for the slot being entered; on entry to slot 0 it is the old R LSB.
      dout_d  = shift_q[FW-1];
      shift_d = {shift_q[FW-2:0], 1'b0};
      if (load) begin
        shift_d = ready_q ? '0 : hold_q;
      end
    end

    if (load && !ready_q) begin
      ready_d = 1'b1;
    end
    if (xfer) begin
      hold_d  = {sample_left, sample_right};
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      slot_q     <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      ready_q    <= 1'b1;
      lrclk_q    <= 1'b0;
      dout_q     <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      ready_q    <= ready_d;
      lrclk_q    <= lrclk_d;
      dout_q     <= dout_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_ready = ready_q;
  assign frame_tick   = tick_q;
  assign underrun     = underrun_q;
  assign audio_lrclk  = lrclk_q;
  assign audio_dout   = dout_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Two configurations (8/16 and 2/24) run the same scenario script against a cycle-count reference model;
// a serial decoder pops expected frames from a scoreboard queue filled at each predicted frame load.
module tb_i2s_transmitter;
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  bit done [2];

  task automatic chk(input int id, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", id, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N  = (g == 0) ? 8 : 2;
    localparam int W  = (g == 0) ? 16 : 24;
    localparam int FW = 2 * W;
    localparam int FR = 2 * N * FW;
    localparam logic [W-1:0] DL = (g == 0) ? W'(32'h0000A5F0) : W'(32'h00800001);
    localparam logic [W-1:0] DR = (g == 0) ? W'(32'h00000F0F) : W'(32'h005A0FF1);

    logic         rst_n = 1'b0;
    logic [W-1:0] left  = '0;
    logic [W-1:0] right = '0;
    logic         vld   = 1'b0;
    logic         rdy, tick, und, bclk, lrclk, dout;

    i2s_transmitter #(.SAMPLE_WIDTH(W), .CLK_DIV_HALF(N)) dut (
      .aclk         (aclk),
      .aresetn      (rst_n),
      .sample_left  (left),
      .sample_right (right),
      .sample_valid (vld),
      .sample_ready (rdy),
      .frame_tick   (tick),
      .underrun     (und),
      .audio_bclk   (bclk),
      .audio_lrclk  (lrclk),
      .audio_dout   (dout)
    );

    // Reference: frames load every FR clks after reset release; whatever is held then plays, else zeros.
    int            cyc = 0;
    bit            live = 0;
    bit            m_full, m_tick, m_und;
    logic [FW-1:0] m_hold, cur, prev;
    logic [FW-1:0] exp_q [$];

    always @(posedge aclk) begin : model
      bit load, xfer;
      if (!rst_n) begin
        live = 1; cyc = 0; m_full = 0; m_tick = 0; m_und = 0;
        m_hold = '0; cur = '0; prev = '0;
        exp_q.delete();
        exp_q.push_back('0);
      end else if (live) begin
        load   = ((cyc + 1) % FR) == 0;
        xfer   = vld && !m_full;
        m_tick = load;
        m_und  = load && !m_full;
        if (load) begin
          prev = cur;
          cur  = m_full ? m_hold : '0;
          exp_q.push_back(cur);
          m_full = 0;
        end
        if (xfer) begin
          m_hold = {left, right};
          m_full = 1;
        end
        cyc++;
      end
    end

    logic [FW-1:0] rx;
    bit            prev_b, prev_lr, lr_fell;

    always @(negedge aclk) begin : monitor
      int slot;
      if (!rst_n) begin
        rx = '0; prev_b = 0; prev_lr = 0; lr_fell = 0;
      end else if (live) begin
        slot = (cyc / (2 * N)) % FW;
        chk(g, "bclk", bclk, (cyc / N) % 2);
        chk(g, "lrclk", lrclk, (slot >= W - 1 && slot <= FW - 2) ? 1 : 0);
        chk(g, "dout", dout, (slot == 0) ? prev[0] : cur[FW-slot]);
        chk(g, "sample_ready", rdy, !m_full);
        chk(g, "frame_tick", tick, m_tick);
        chk(g, "underrun", und, m_und);
        if (bclk && !prev_b) begin
          rx = {rx[FW-2:0], dout};
          if (lr_fell) begin
            chk(g, "frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk(g, "frame", rx, exp_q.pop_front());
          end
          lr_fell = prev_lr && !lrclk;
          prev_lr = lrclk;
        end
        prev_b = bclk;
      end
    end

    task automatic idle(input int n);
      repeat (n) begin @(posedge aclk); #2; end
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
      bit took = 0;
      int n = 0;
      left = l; right = r; vld = 1;
      while (!took && n < 2 * FR) begin
        took = rdy;
        @(posedge aclk); #2;
        n++;
      end
      vld = 0;
      chk(g, "send_accepted", took, 1);
    endtask

    task automatic wait_phase(input int m);
      int n = 0;
      while ((cyc % FR) != m && n < 2 * FR) begin @(posedge aclk); #2; n++; end
      chk(g, "wait_phase", cyc % FR, m);
    endtask

    initial begin : stim
      int  ctr;
      bit  took;
      repeat (3) @(posedge aclk);
      #2 rst_n = 1;
      idle(2 * FR);

      send(DL, DR);
      idle(2 * FR);

      ctr = 1; vld = 1; left = W'(ctr); right = ~W'(ctr);
      repeat (6 * FR) begin
        took = rdy;
        @(posedge aclk); #2;
        if (took) begin ctr++; left = W'(ctr); right = ~W'(ctr); end
      end
      vld = 0;
      chk(g, "stream_rate", (ctr - 1 >= 5 && ctr - 1 <= 7) ? 1 : 0, 1);
      idle(FR);

      wait_phase(FR - 1);
      left = W'($urandom); right = W'($urandom); vld = 1;
      @(posedge aclk); #2;
      vld = 0;
      chk(g, "coincident_underrun", und, 1);
      chk(g, "coincident_ready", rdy, 0);
      idle(3 * FR);

      repeat (4 * FR) begin
        vld = ($urandom_range(0, 3) == 0);
        left = W'($urandom); right = W'($urandom);
        @(posedge aclk); #2;
      end
      vld = 0;
      idle(2 * FR);

      wait_phase(2 * N * 2);
      send(W'($urandom), W'($urandom));
      wait_phase(2 * N * 20);
      chk(g, "held_before_reset", rdy, 0);
      rst_n = 0;
      @(posedge aclk); #2;
      rst_n = 1;
      chk(g, "rst_bclk", bclk, 0);
      chk(g, "rst_lrclk", lrclk, 0);
      chk(g, "rst_dout", dout, 0);
      chk(g, "rst_ready", rdy, 1);
      idle(2 * FR + 4 * N);
      done[g] = 1;
    end
  end

  initial begin : finisher
    int n = 0;
    while (!(done[0] && done[1]) && n < 60000) begin
      @(posedge aclk);
      n++;
    end
    chk(9, "run_completed", done[0] && done[1], 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
Serializer stage that sits directly downstream of the audio mixer. It takes one stereo frame at a time over a valid/ready handshake and drives the I2S pins audio_bclk, audio_lrclk and audio_dout. It derives the bit clock from the system clock with a divider and holds one frame in reserve. It gives the mixer a frame_tick pulse at each frame boundary so the mixer can time its sample production.

Parameters:
SAMPLE_WIDTH, 16, bits per channel slot; one frame = 2*SAMPLE_WIDTH bclk periods.
CLK_DIV_HALF, 8, clk cycles per bclk half-period; legal values are >= 2. The default gives 1.5625 MHz bclk and 48.83 kHz fs from 25 MHz.

Ports:
aclk  in  1  system clock; all logic is on its rising edge.
aresetn  in  1  reset; synchronous, active-low.
sample_left  in  SAMPLE_WIDTH  left sample, two's complement.
sample_right  in  SAMPLE_WIDTH  right sample, two's complement.
sample_valid  in  1  the frame on sample_left/right is valid.
sample_ready  out  1  holding register is empty; transfer happens when valid && ready.
frame_tick  out  1  one-cycle pulse when a frame is loaded into the shifter.
underrun  out  1  one-cycle pulse when a frame load finds the holding register empty.
audio_bclk  out  1  I2S bit clock.
audio_lrclk  out  1  I2S word select; 0 = left, 1 = right.
audio_dout  out  1  I2S serial data, MSB first.

Behaviour:
- Reset (aresetn low at a clk edge) applies to every state element. Reset values: audio_bclk=0, audio_lrclk=0, audio_dout=0, sample_ready=1, frame_tick=0, underrun=0, divider=0, slot counter=0, holding register empty, shifter=0.
- A reset asserted mid-frame aborts the frame immediately. Held data is discarded and no pulses are emitted.
- Divider counts 0..CLK_DIV_HALF-1. At the terminal count, audio_bclk toggles and the divider wraps to 0.
  - The first bclk rise comes CLK_DIV_HALF cycles after reset release.
  - bclk period = 2*CLK_DIV_HALF clk cycles.
- Slot counter runs 0..2*SAMPLE_WIDTH-1 and wraps. It advances on the clk edge where bclk goes 1->0.
- audio_lrclk and audio_dout are registered and change only on that falling-edge event. They are stable across each rising edge.
- I2S timing, with W=SAMPLE_WIDTH:
  - audio_lrclk is 1 in slots W-1 .. 2W-2 and 0 otherwise. It leads the data by one bit.
  - audio_dout in slot s carries frame bit (s-1) mod 2W, where frame bits 0..W-1 are L MSB..LSB and bits W..2W-1 are R MSB..LSB.
  - Slot 0 therefore carries the previous frame's R LSB, and slot 1 carries the new L MSB.
- Frame load happens on the falling-edge event that enters slot 0.
  - Holding full: holding is copied to the shifter, holding becomes empty, and frame_tick=1 for that one cycle.
  - Holding empty: the shifter loads all zeros, and frame_tick=1 and underrun=1 for that one cycle.
- Handshake:
  - sample_ready is registered and equals "holding empty".
  - A transfer with holding empty fills holding; sample_ready is 0 from the next cycle.
  - After a frame load, sample_ready is 1 from the next cycle.
  - Inputs are ignored while sample_ready=0.
- Simultaneous transfer and load with holding empty: no bypass. Zeros are loaded and underrun pulses. The transferred frame lands in holding and plays in the next frame.
- Signed data is transmitted verbatim with no width conversion.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_WIDTH default constant;
  - typedef StereoFrame, a packed struct {left, right} of SAMPLE_WIDTH each;
  - I2S_CHANNEL_LEFT=0 / I2S_CHANNEL_RIGHT=1 constants.
- Sub-module i2s_clock_divider (parameter CLK_DIV_HALF) outputs:
  - bclk;
  - bclk_fall_en, a one-cycle enable on the 1->0 toggle;
  - bclk_rise_en.

Test Plan:
1. Release reset, hold sample_valid=0 → first bclk rise at clk 8. bclk period is 16 clks and lrclk period is 512 clks. underrun pulses once per frame and dout stays 0.
2. Offer L=16'hA5F0, R=16'h0F0F once → at the next frame_tick, slots 1..16 carry 1010010111110000 and slots 17..31 plus the next slot 0 carry 0000111100001111. lrclk is high for slots 15..30. No underrun on that frame.
3. Hold sample_valid=1 continuously with an incrementing counter → one transfer per frame, each accepted the cycle after the preceding frame_tick. underrun never asserts and the decoded frames are sequential with no duplicates.
4. Assert sample_valid in the same cycle as a frame load with holding empty → underrun=1 and zeros play for that frame. The offered frame plays in the following frame and sample_ready is 0 until the next frame_tick.
5. Pull aresetn low for 1 cycle at slot 20 with holding full → the next cycle shows bclk=0, lrclk=0, dout=0 and sample_ready=1. The held frame is never emitted and timing restarts exactly as in scenario 1.
6. With CLK_DIV_HALF=2 and SAMPLE_WIDTH=24 → bclk period is 4 clks, the frame is 48 bclks, and lrclk is high for slots 23..46. A 24'h800001 frame serializes MSB-first with the one-bit delay.
